// File: rtl/store_pkg.sv
// Shared store-size encodings and lane helper for the store buffer.
package store_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } st_size_e;

    // Bytes touched by an access of the given size, clamped to the memory width.
    function automatic int unsigned lane_bytes(input st_size_e size, input int unsigned lanes);
        int unsigned b;
        b = 32'd1 << size;
        return (b > lanes) ? lanes : b;
    endfunction

endpackage

// File: rtl/store_lane_fmt.sv
// Combinational lane formatter: aligns address, shifts data and builds byte enables.
module store_lane_fmt
    import store_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]   addr,
    input  logic [1:0]          size,
    input  logic [DATA_W-1:0]   data,
    output logic [ADDR_W-1:0]   line_addr,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] be,
    output logic                misaligned
);

    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(LANES);

    logic [OFF_W:0]   nbytes;
    logic [OFF_W-1:0] off;
    logic [OFF_W-1:0] mask_lo;
    logic [OFF_W-1:0] off_al;

    always_comb begin
        nbytes     = (OFF_W + 1)'(lane_bytes(st_size_e'(size), LANES));
        mask_lo    = OFF_W'(nbytes - 1'b1);
        off        = addr[OFF_W-1:0];
        misaligned = |(off & mask_lo);
        // Offset rounded down to a multiple of the access size.
        off_al     = off & ~mask_lo;
        line_addr  = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        wdata      = '0;
        be         = '0;
        for (int j = 0; j < int'(LANES); j++) begin
            if (j >= int'(off_al) && j < int'(off_al) + int'(nbytes)) begin
                be[j]          = 1'b1;
                wdata[j*8 +: 8] = data[(j - int'(off_al))*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/store_buffer_align.sv
// Store buffer FIFO with lane alignment. Define STORE_MISALIGN_TRAP_EN to drop
// misaligned stores and flag them on misalign_err instead of force-aligning.
module store_buffer_align
    import store_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [1:0]                 st_size,
    input  logic [DATA_W-1:0]          st_data,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic [DATA_W/8-1:0]        mem_be,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       misalign_err
);

    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [LANES-1:0]  be_mem   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rdy_en_q;

    logic [ADDR_W-1:0] fmt_addr;
    logic [DATA_W-1:0] fmt_wdata;
    logic [LANES-1:0]  fmt_be;
    logic              fmt_misaligned;
    logic              accept, retire, push;

    store_lane_fmt #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fmt (
        .addr       (st_addr),
        .size       (st_size),
        .data       (st_data),
        .line_addr  (fmt_addr),
        .wdata      (fmt_wdata),
        .be         (fmt_be),
        .misaligned (fmt_misaligned)
    );

    // rdy_en_q keeps st_ready low while in reset and until the first edge after release.
    assign st_ready  = rdy_en_q && (count_q < CNT_W'(DEPTH));
    assign mem_valid = (count_q != '0);
    assign accept    = st_valid && st_ready;
    assign retire    = mem_valid && mem_ready;
    assign count     = count_q;
    assign mem_addr  = addr_mem[rd_ptr_q];
    assign mem_wdata = data_mem[rd_ptr_q];
    assign mem_be    = be_mem[rd_ptr_q];

`ifdef STORE_MISALIGN_TRAP_EN
    logic err_q;

    assign push         = accept && !fmt_misaligned;
    assign misalign_err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept && fmt_misaligned) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_misaligned;

    assign push              = accept;
    assign misalign_err      = 1'b0;
    assign unused_misaligned = fmt_misaligned;
`endif

    always_comb begin
        count_d = count_q;
        if (push && !retire) begin
            count_d = count_q + 1'b1;
        end else if (retire && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdy_en_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
                be_mem[i]   <= '0;
            end
        end else begin
            rdy_en_q <= 1'b1;
            count_q  <= count_d;
            if (push) begin
                addr_mem[wr_ptr_q] <= fmt_addr;
                data_mem[wr_ptr_q] <= fmt_wdata;
                be_mem[wr_ptr_q]   <= fmt_be;
                wr_ptr_q           <= wr_ptr_q + 1'b1;
            end
            if (retire) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer_align.sv
// Directed, table-driven bench for store_buffer_align (DATA_W=32, DEPTH=4).
module tb_store_buffer_align;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              st_valid = 1'b0;
    logic              st_ready;
    logic [31:0]       st_addr = '0;
    logic [1:0]        st_size = '0;
    logic [31:0]       st_data = '0;
    logic              mem_valid;
    logic              mem_ready = 1'b0;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic [2:0]        count;
    logic              misalign_err;

    int checks = 0;
    int errors = 0;

    store_buffer_align #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_addr      (st_addr),
        .st_size      (st_size),
        .st_data      (st_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .count        (count),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_size  = s;
        st_data  = d;
    endtask

    vec_t vecs [7];
    logic [31:0] exp_q [$];

    initial begin
        vecs[0] = '{32'h1003, 2'd0, 32'h0000_00AB, 32'h1000, 32'hAB00_0000, 4'b1000};
        vecs[1] = '{32'h2002, 2'd1, 32'h1234_CDEF, 32'h2000, 32'hCDEF_0000, 4'b1100};
        vecs[2] = '{32'h4000, 2'd2, 32'hDEAD_BEEF, 32'h4000, 32'hDEAD_BEEF, 4'b1111};
        vecs[3] = '{32'h5001, 2'd0, 32'hFFFF_FF5A, 32'h5000, 32'h0000_5A00, 4'b0010};
        vecs[4] = '{32'h6000, 2'd1, 32'hAAAA_1357, 32'h6000, 32'h0000_1357, 4'b0011};
        vecs[5] = '{32'h7000, 2'd3, 32'h0123_4567, 32'h7000, 32'h0123_4567, 4'b1111};
        vecs[6] = '{32'h8FFC, 2'd2, 32'hCAFE_F00D, 32'h8FFC, 32'hCAFE_F00D, 4'b1111};

        // Reset state
        #2;
        check("rst_count", 32'(count), 0);
        check("rst_mem_valid", 32'(mem_valid), 0);
        check("rst_st_ready", 32'(st_ready), 0);
        check("rst_misalign", 32'(misalign_err), 0);
        check("rst_mem_be", 32'(mem_be), 0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_st_ready", 32'(st_ready), 1);

        // Single-store formatting table
        foreach (vecs[i]) begin
            set_store(vecs[i].addr, vecs[i].size, vecs[i].data);
            step();
            st_valid = 1'b0;
            check($sformatf("v%0d_mem_valid", i), 32'(mem_valid), 1);
            check($sformatf("v%0d_count", i), 32'(count), 1);
            check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].exp_wdata);
            check($sformatf("v%0d_mem_be", i), 32'(mem_be), 32'(vecs[i].exp_be));
            mem_ready = 1'b1;
            step();
            mem_ready = 1'b0;
            check($sformatf("v%0d_drained", i), 32'(count), 0);
        end

        // Misaligned word store
        set_store(32'h3001, 2'd2, 32'h1122_3344);
        step();
        st_valid = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
        check("mis_count", 32'(count), 0);
        check("mis_err", 32'(misalign_err), 1);
        step();
        check("mis_err_sticky", 32'(misalign_err), 1);
`else
        check("mis_count", 32'(count), 1);
        check("mis_err", 32'(misalign_err), 0);
        check("mis_addr", mem_addr, 32'h3000);
        check("mis_be", 32'(mem_be), 32'hF);
        check("mis_wdata", mem_wdata, 32'h1122_3344);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        // Misaligned half rounds down to lane offset 2
        set_store(32'h2003, 2'd1, 32'h0000_BEEF);
        step();
        st_valid = 1'b0;
        check("mis_h_be", 32'(mem_be), 32'hC);
        check("mis_h_wdata", mem_wdata, 32'hBEEF_0000);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
`endif
        check("mis_drained", 32'(count), 0);

        // Fill to DEPTH with memory stalled; the fifth store must be refused
        for (int i = 0; i < 5; i++) begin
            set_store(32'h100 + 32'(i) * 4, 2'd2, 32'hB000_0000 + 32'(i));
            check($sformatf("fill%0d_st_ready", i), 32'(st_ready), (i < 4) ? 1 : 0);
            step();
        end
        st_valid = 1'b0;
        check("full_count", 32'(count), 4);
        check("full_st_ready", 32'(st_ready), 0);
        check("full_head_stable", mem_wdata, 32'hB000_0000);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check("after_pop_st_ready", 32'(st_ready), 1);
        check("after_pop_count", 32'(count), 3);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("drain%0d_wdata", i), mem_wdata, 32'hB000_0000 + 32'(i));
            mem_ready = 1'b1;
            step();
            mem_ready = 1'b0;
        end
        check("drain_count", 32'(count), 0);

        // Steady accept+retire at count 1; pointers wrap twice over 10 cycles
        set_store(32'h200, 2'd2, 32'hC000_0000);
        exp_q.push_back(32'hC000_0000);
        step();
        for (int i = 1; i <= 10; i++) begin
            set_store(32'h200 + 32'(i) * 4, 2'd2, 32'hC000_0000 + 32'(i));
            mem_ready = 1'b1;
            check($sformatf("stream%0d_count", i), 32'(count), 1);
            check($sformatf("stream%0d_wdata", i), mem_wdata, exp_q.pop_front());
            exp_q.push_back(32'hC000_0000 + 32'(i));
            step();
        end
        st_valid  = 1'b0;
        mem_ready = 1'b0;
        check("stream_end_count", 32'(count), 1);
        check("stream_end_wdata", mem_wdata, exp_q.pop_front());
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;

        // Asynchronous reset with three entries pending
        for (int i = 0; i < 3; i++) begin
            set_store(32'h300 + 32'(i) * 4, 2'd2, 32'hD000_0001 + 32'(i));
            step();
        end
        st_valid = 1'b0;
        check("pre_arst_count", 32'(count), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_mem_valid", 32'(mem_valid), 0);
        check("arst_st_ready", 32'(st_ready), 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_mem_wdata", mem_wdata, 0);
        check("arst_mem_be", 32'(mem_be), 0);
        check("arst_misalign", 32'(misalign_err), 0);
        step();
        rst_n = 1'b1;
        step();
        check("rel_count", 32'(count), 0);
        check("rel_st_ready", 32'(st_ready), 1);
        check("rel_mem_valid", 32'(mem_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_buffer_align.md
STORE_BUFFER_ALIGN -- requirements
Module: store_buffer_align

Interface
REQ-001 Parameter DATA_W, default 32, memory data width in bits; SHALL be a multiple of 8, range 32..128.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Parameter DEPTH, default 4, store-buffer entries; SHALL be a power of two and at least 2.
REQ-004 Port clk, input, 1, single clock; all state SHALL update on the rising edge.
REQ-005 Port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 Port st_valid, input, 1, a store request is present.
REQ-007 Port st_ready, output, 1, the buffer can accept a store this cycle.
REQ-008 Port st_addr, input, ADDR_W, byte address.
REQ-009 Port st_size, input, 2, access size: 0 = byte, 1 = half, 2 = word, 3 = doubleword.
REQ-010 Port st_data, input, DATA_W, store data, right-justified.
REQ-011 Port mem_valid, output, 1, the head entry is presented to memory.
REQ-012 Port mem_ready, input, 1, memory accepts the head entry.
REQ-013 Port mem_addr, output, ADDR_W, lane-aligned address with the low log2(DATA_W/8) bits zero.
REQ-014 Port mem_wdata, output, DATA_W, lane-shifted write data.
REQ-015 Port mem_be, output, DATA_W/8, byte enables.
REQ-016 Port count, output, log2(DEPTH)+1, number of occupied entries.
REQ-017 Port misalign_err, output, 1, sticky misaligned-store flag.

Function
REQ-018 A store SHALL be accepted on a cycle where st_valid and st_ready are both high; a beat SHALL retire on a cycle where mem_valid and mem_ready are both high.
REQ-019 st_ready SHALL equal (count < DEPTH) and SHALL NOT depend combinationally on mem_ready; there is no full-bypass.
REQ-020 Byte count SHALL be 2^st_size; any size above DATA_W/8 bytes SHALL be clamped to DATA_W/8.
REQ-021 Lane offset SHALL be st_addr[log2(DATA_W/8)-1:0]; mem_wdata SHALL be st_data, masked to the byte count, shifted left by offset×8; mem_be SHALL be ((1<<bytes)-1)<<offset; all remaining bytes SHALL be zero.
REQ-022 A store is misaligned when offset mod bytes is nonzero.
REQ-023 Entries SHALL leave in FIFO order; a store accepted in cycle N SHALL appear on mem_* no earlier than N+1, with mem_* driven from registers.
REQ-024 mem_valid SHALL equal (count != 0); mem_addr, mem_wdata and mem_be SHALL hold stable while mem_valid is high and mem_ready is low.
REQ-025 Simultaneous accept and retire SHALL leave count unchanged, and this SHALL be legal at count == DEPTH-1 and at count == 1.
REQ-026 When full, count SHALL be DEPTH and st_ready SHALL be 0; a retire in that cycle SHALL raise st_ready in the next cycle.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-028 While rst_n is low: count = 0, mem_valid = 0, st_ready = 0, misalign_err = 0, pointers = 0, mem_addr/mem_wdata/mem_be = 0.
REQ-029 st_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-030 Reset asserted mid-operation SHALL discard all entries; an in-flight beat SHALL be lost without retry.

Configuration
REQ-031 With macro STORE_MISALIGN_TRAP_EN defined, a misaligned store SHALL be accepted, that is, consume the handshake, but not enqueued; misalign_err SHALL set the next cycle and stay set until reset.
REQ-032 Without STORE_MISALIGN_TRAP_EN, the offset SHALL be rounded down to a multiple of bytes (force-aligned) and the store enqueued; misalign_err SHALL be tied to 0.

Structure
REQ-033 A shared package store_pkg SHALL hold the size encodings (SZ_B, SZ_H, SZ_W, SZ_D) and the lane-count function.
REQ-034 Combinational lane formatting SHALL live in sub-module store_lane_fmt, instantiated once on the write side; the FIFO storage and pointers SHALL live in the top level.

Verification
REQ-035 With DATA_W=32, store addr 0x1003, size 0, data 0xAB: mem_addr 0x1000, mem_wdata 0xAB000000, mem_be 4'b1000, one cycle after accept.
REQ-036 With DATA_W=32, half store at addr 0x2002, data 0x1234CDEF: mem_wdata 0x12340000... correction, mem_wdata 0xCDEF0000, mem_be 4'b1100.
REQ-037 With DEPTH=4 and mem_ready=0, issue 5 stores: st_ready low after 4 accepts, count 4; then a single mem_ready pulse retires entry 0 and st_ready rises next cycle.
REQ-038 With count=1, continuous accept and retire for 10 cycles: count stays 1, order preserved, and pointers wrap twice.
REQ-039 Word store at addr 0x3001: with STORE_MISALIGN_TRAP_EN, count unchanged and misalign_err=1; without it, mem_addr 0x3000 and mem_be 4'b1111.
REQ-040 Assert rst_n low with count=3 and mem_valid high: all outputs SHALL read 0 immediately (asynchronous), and count SHALL be 0 after release.
